// File: rtl/i2s_oversampled_rx.sv
// I2S receiver running entirely in the sys_clk domain: oversamples bclk/lrclk/data,
// deserialises left/right words and emits a stereo pair with a single-cycle valid pulse.
module i2s_oversampled_rx #(
  parameter int unsigned I2S_WIDTH      = 24,
  parameter int unsigned SLOT_WIDTH     = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 i2s_bclk,
  input  logic                 i2s_lrclk,
  input  logic                 i2s_data,
  output logic [I2S_WIDTH-1:0] left_sample,
  output logic [I2S_WIDTH-1:0] right_sample,
  output logic                 sample_valid,
  output logic                 frame_error,
  output logic                 link_up
);

  localparam int unsigned CntW = $clog2(SLOT_WIDTH + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] WordLen = CntW'(I2S_WIDTH);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] bclk_sync_q, ws_sync_q, data_sync_q;
  logic                   bclk_s, ws_s, data_s;
  logic                   bclk_prev_q, bclk_rise;

  logic                 ws_dly_q, ws_dly_d;
  logic                 ws_prev_q, ws_prev_d;
  logic                 aligned_q, aligned_d;
  logic                 left_done_q, left_done_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [I2S_WIDTH-1:0] shift_q, shift_d;
  logic [I2S_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [I2S_WIDTH-1:0] left_q, left_d;
  logic [I2S_WIDTH-1:0] right_q, right_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 link_q, link_d;

  // Synchronisers carry no reset; they flush within SYNC_STAGES cycles.
  always_ff @(posedge sys_clk) begin
    bclk_sync_q[0] <= i2s_bclk;
    ws_sync_q[0]   <= i2s_lrclk;
    data_sync_q[0] <= i2s_data;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      bclk_sync_q[i] <= bclk_sync_q[i-1];
      ws_sync_q[i]   <= ws_sync_q[i-1];
      data_sync_q[i] <= data_sync_q[i-1];
    end
    bclk_prev_q <= bclk_s;
  end

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign ws_s      = ws_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;

  always_comb begin
    ws_dly_d    = ws_dly_q;
    ws_prev_d   = ws_prev_q;
    aligned_d   = aligned_q;
    left_done_d = left_done_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    tmo_d       = tmo_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    if (bclk_rise) begin
      tmo_d     = '0;
      ws_dly_d  = ws_s;
      ws_prev_d = ws_dly_q;
      // The bit on this edge belongs to ws_dly_q (one-bit WS lead).
      if (ws_dly_q != ws_prev_q) begin
        if (!aligned_q) begin
          aligned_d = 1'b1;
        end else if (bit_cnt_q < WordLen) begin
          ferr_d      = 1'b1;
          left_done_d = 1'b0;
        end
        if (!ws_dly_q) begin
          left_done_d = 1'b0;
        end
        bit_cnt_d = CntW'(1);
        shift_d   = {{(I2S_WIDTH-1){1'b0}}, data_s};
      end else if (bit_cnt_q < WordLen) begin
        shift_d   = {shift_q[I2S_WIDTH-2:0], data_s};
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (aligned_q && (bit_cnt_d == WordLen)) begin
          if (!ws_dly_q) begin
            left_hold_d = shift_d;
            left_done_d = 1'b1;
          end else if (left_done_q) begin
            left_d      = left_hold_q;
            right_d     = shift_d;
            valid_d     = 1'b1;
            left_done_d = 1'b0;
          end
        end
      end
    end else if (tmo_q != TmoMax) begin
      tmo_d = tmo_q + TmoW'(1);
    end

    if (tmo_d == TmoMax) begin
      aligned_d   = 1'b0;
      left_done_d = 1'b0;
    end
    link_d = aligned_d && (tmo_d != TmoMax);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      // Track the live word select so a reset mid-slot does not fake a slot start.
      ws_dly_q    <= ws_s;
      ws_prev_q   <= ws_s;
      aligned_q   <= 1'b0;
      left_done_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      tmo_q       <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      link_q      <= 1'b0;
    end else begin
      ws_dly_q    <= ws_dly_d;
      ws_prev_q   <= ws_prev_d;
      aligned_q   <= aligned_d;
      left_done_q <= left_done_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      tmo_q       <= tmo_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      link_q      <= link_d;
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = valid_q;
  assign frame_error  = ferr_q;
  assign link_up      = link_q;

endmodule

// File: tb/tb_i2s_oversampled_rx.sv
// Randomised bench for i2s_oversampled_rx: drives I2S slot lists and compares the
// captured stereo pairs and frame errors against a slot-level reference model.
module tb_i2s_oversampled_rx;

  localparam int W    = 24;
  localparam int SLOT = 32;
  localparam int TMO  = 256;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         i2s_bclk = 1'b0;
  logic         i2s_lrclk = 1'b0;
  logic         i2s_data = 1'b0;
  logic [W-1:0] left_sample, right_sample;
  logic         sample_valid, frame_error, link_up;

  i2s_oversampled_rx #(
    .I2S_WIDTH     (W),
    .SLOT_WIDTH    (SLOT),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_data    (i2s_data),
    .left_sample (left_sample),
    .right_sample(right_sample),
    .sample_valid(sample_valid),
    .frame_error (frame_error),
    .link_up     (link_up)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit           ch;  // 0 = left, 1 = right
    int           n;   // bclks in the slot
    logic [W-1:0] w;
  } slot_t;

  slot_t          slots[$];
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] act_q[$];
  int             exp_fe = 0;
  int             act_fe = 0;
  longint         cyc = 0;
  longint         last_rise_cyc = 0;

  always @(posedge sys_clk) cyc++;

  int sv_run = 0;
  int fe_run = 0;
  always @(negedge sys_clk) begin
    if (sample_valid) begin
      act_q.push_back({left_sample, right_sample});
      sv_run++;
    end else begin
      if (sv_run > 0) check_eq("sample_valid_width", sv_run, 1);
      sv_run = 0;
    end
    if (frame_error) begin
      act_fe++;
      fe_run++;
    end else begin
      if (fe_run > 0) check_eq("frame_error_width", fe_run, 1);
      fe_run = 0;
    end
  end

  // Slot-level model: slot 0 of a session is never a slot start; a reset inside
  // reset_slot wipes state after that slot's start has been evaluated.
  function automatic void model(input int reset_slot);
    bit           aligned = 0;
    bit           ld = 0;
    logic [W-1:0] hold = '0;
    for (int s = 0; s < slots.size(); s++) begin
      if (s > 0) begin
        if (aligned && slots[s-1].n < W) begin
          exp_fe++;
          ld = 0;
        end
        aligned = 1;
        if (!slots[s].ch) ld = 0;
      end
      if (s == reset_slot) begin
        aligned = 0;
        ld = 0;
        continue;
      end
      if (aligned && slots[s].n >= W) begin
        if (!slots[s].ch) begin
          hold = slots[s].w;
          ld = 1;
        end else if (ld) begin
          exp_q.push_back({hold, slots[s].w});
          ld = 0;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_eq("rst_left", left_sample, 0);
    check_eq("rst_right", right_sample, 0);
    check_eq("rst_valid", sample_valid, 0);
    check_eq("rst_ferr", frame_error, 0);
    check_eq("rst_link", link_up, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic drive_session(input int reset_slot, input int reset_off);
    logic bits[$];
    bit   chs[$];
    int   rst_bit = -1;
    bit   ws;
    for (int s = 0; s < slots.size(); s++) begin
      for (int j = 0; j < slots[s].n; j++) begin
        if (s == reset_slot && j == reset_off) rst_bit = bits.size();
        bits.push_back(j < W ? slots[s].w[W-1-j] : 1'($urandom));
        chs.push_back(slots[s].ch);
      end
    end
    for (int t = 0; t < bits.size(); t++) begin
      ws = (t + 1 < bits.size()) ? chs[t+1] : chs[t];
      if (t == rst_bit) do_reset();
      @(negedge sys_clk);
      i2s_bclk  = 1'b0;
      i2s_lrclk = ws;
      i2s_data  = bits[t];
      repeat (3) @(negedge sys_clk);
      i2s_bclk      = 1'b1;
      last_rise_cyc = cyc;
      repeat (4) @(negedge sys_clk);
    end
    i2s_bclk = 1'b0;
  endtask

  task automatic check_session(input string name);
    int n;
    repeat (20) @(negedge sys_clk);
    check_eq({name, "_pairs"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("%s_pair%0d", name, i), act_q[i], exp_q[i]);
    check_eq({name, "_frame_errors"}, act_fe, exp_fe);
    act_q.delete();
    exp_q.delete();
    act_fe = 0;
    exp_fe = 0;
  endtask

  task automatic idle_timeout(input string name);
    bit seen = 0;
    int lat;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge sys_clk);
      if (!link_up) seen = 1;
    end
    lat = int'(cyc - last_rise_cyc);
    check_eq({name, "_link_down_seen"}, seen, 1);
    check_eq({name, "_link_down_latency_ok"}, (lat >= TMO && lat <= TMO + 8), 1);
    repeat (50) @(negedge sys_clk);
  endtask

  function automatic void add_slot(input bit ch, input int n, input logic [W-1:0] w);
    slot_t s;
    s.ch = ch;
    s.n  = n;
    s.w  = w;
    slots.push_back(s);
  endfunction

  function automatic void add_rand_frames(input int k, input int lo, input int hi);
    for (int i = 0; i < k; i++) begin
      add_slot(0, int'($urandom_range(hi, lo)), W'($urandom));
      add_slot(1, int'($urandom_range(hi, lo)), W'($urandom));
    end
  endfunction

  int rs;

  initial begin
    i2s_lrclk = 1'b0;
    repeat (4) @(negedge sys_clk);
    check_eq("init_left", left_sample, 0);
    check_eq("init_right", right_sample, 0);
    check_eq("init_valid", sample_valid, 0);
    check_eq("init_ferr", frame_error, 0);
    check_eq("init_link", link_up, 0);
    sys_rst = 1'b0;

    // Session 1: partial first frame, fixed words, 24-bclk slots, short slot, random.
    slots.delete();
    add_slot(0, SLOT, W'($urandom));
    add_slot(1, SLOT, 24'h123456);
    for (int i = 0; i < 4; i++) begin
      add_slot(0, SLOT, 24'hABCDEF);
      add_slot(1, SLOT, 24'h123456);
    end
    for (int i = 0; i < 3; i++) begin
      add_slot(0, W, 24'h800001);
      add_slot(1, W, 24'h000001);
    end
    add_slot(0, 16, W'($urandom));
    add_slot(1, SLOT, W'($urandom));
    add_slot(0, SLOT, 24'hABCDEF);
    add_slot(1, SLOT, 24'h123456);
    add_rand_frames(6, W, SLOT);
    model(-1);
    drive_session(-1, 0);
    check_eq("s1_link_up", link_up, 1);
    check_session("s1");

    idle_timeout("s1");
    check_eq("s1_link_idle", link_up, 0);

    // Session 2: restart in the right slot, then a reset mid-right-slot.
    slots.delete();
    add_slot(1, SLOT, W'($urandom));
    add_rand_frames(2, W, SLOT);
    add_slot(0, SLOT, W'($urandom));
    add_slot(1, SLOT, W'($urandom));
    rs = slots.size() - 1;
    add_rand_frames(3, W, SLOT);
    model(rs);
    drive_session(rs, 10);
    check_eq("s2_link_up", link_up, 1);
    check_session("s2");

    idle_timeout("s2");

    // Session 3: traffic begins at the start of a right slot after reset.
    i2s_lrclk = 1'b1;
    do_reset();
    slots.delete();
    add_slot(1, SLOT, W'($urandom));
    add_rand_frames(3, W, SLOT);
    model(-1);
    drive_session(-1, 0);
    check_eq("s3_link_up", link_up, 1);
    check_session("s3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
